enter_input_conditioner: RTL

- Front-end stage that sits directly upstream of the control/datapath pair.
- Takes the raw active-low push-button `nenter` and the raw 8-bit switch bus `inputdata`, and double-flop synchronizes both.
- Debounces the button with a press/release state machine and emits one clean single-cycle `enter_pulse` per physical press.
- On each press, captures the switch value into a valid/ready holding register consumed by the datapath; an overrun flag reports presses lost while data was pending.

---
 rtl/enter_input_conditioner.sv | 133 +++++++++++++
 1 files changed

// File: rtl/enter_input_conditioner.sv
// Button/switch front end: 2-flop synchronizers, press/release debounce FSM,
// single-cycle enter strobe and a valid/ready holding register with overrun.
module enter_input_conditioner #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  nenter,
  input  logic [DATA_WIDTH-1:0] inputdata,
  input  logic                  data_ready,
  input  logic                  clr_overrun,
  output logic                  enter_pulse,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  accept;
  logic                  capture;
  logic                  nenter_m, nenter_s;
  logic [DATA_WIDTH-1:0] data_m, data_s;

  // Button idles high so its synchronizer resets to the released level.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nenter_m <= 1'b1;
      nenter_s <= 1'b1;
      data_m   <= '0;
      data_s   <= '0;
    end else begin
      nenter_m <= nenter;
      nenter_s <= nenter_m;
      data_m   <= inputdata;
      data_s   <= data_m;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (!nenter_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (nenter_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (nenter_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        // A low sample here is release bounce: fall back to HELD, no new pulse.
        if (!nenter_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // A capture on the same edge as an ack replaces the old word instead of dropping it.
  assign capture = accept && (!data_valid || data_ready);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      enter_pulse <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      enter_pulse <= accept;
      if (capture) begin
        data_out   <= data_s;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (accept && data_valid && !data_ready)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

endmodule
